// File: rtl/branch_unit_if.sv
// Bus between the branch unit, the PC, instruction memory, the register
// file and the sequencing bench. The slave side is the branch unit itself.
interface branch_unit_if #(
  parameter int PC_WIDTH    = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int INSTR_WIDTH = 9
);
  logic                    start;
  logic                    done;
  logic [PC_WIDTH-1:0]     current_pc;
  logic [PC_WIDTH-1:0]     instr_addr;
  logic [INSTR_WIDTH-1:0]  instr_data;
  logic [DATA_WIDTH-1:0]   cmp_a;
  logic [DATA_WIDTH-1:0]   cmp_b;
  logic                    EQ;
  logic                    LT;
  logic                    GT;
  logic [1:0]              cond_sel;
  logic                    abs_branch_en;
  logic                    rel_branch_en;
  logic signed [3:0]       rel_branch_offset;
  logic [PC_WIDTH-1:0]     next_pc;
  logic                    lut_we;
  logic [3:0]              lut_waddr;
  logic [PC_WIDTH-1:0]     lut_wdata;
  logic [15:0]             taken_count;

  modport slave (
    input  start, current_pc, instr_data, cmp_a, cmp_b,
           lut_we, lut_waddr, lut_wdata,
    output done, instr_addr, EQ, LT, GT, cond_sel, abs_branch_en,
           rel_branch_en, rel_branch_offset, next_pc, taken_count
  );

  modport master (
    output start, current_pc, instr_data, cmp_a, cmp_b,
           lut_we, lut_waddr, lut_wdata,
    input  done, instr_addr, EQ, LT, GT, cond_sel, abs_branch_en,
           rel_branch_en, rel_branch_offset, next_pc, taken_count
  );
endinterface

// File: rtl/branch_unit.sv
// Branch unit: decodes the fetched instruction, keeps the compare flags,
// the absolute branch-target table, the program sequencer FSM and the
// taken-branch counter for the current program.
module branch_unit #(
  parameter int PC_WIDTH    = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int INSTR_WIDTH = 9
) (
  input  logic        clk,
  input  logic        reset,
  branch_unit_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_BRA = 3'b111;
  localparam logic [2:0] OP_BRR = 3'b101;
  localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = INSTR_WIDTH'(9'b000111111);

  logic [1:0]          state_q, state_d;
  logic                eq_q, eq_d;
  logic                lt_q, lt_d;
  logic                gt_q, gt_d;
  logic [15:0]         taken_count_q, taken_count_d;
  logic [PC_WIDTH-1:0] lut_q [16];
  logic [PC_WIDTH-1:0] lut_d [16];

  logic [2:0] op;
  logic [1:0] cond;
  logic [3:0] field;
  logic       run;
  logic       is_cmp, is_bra, is_brr, is_halt;
  logic       sel_flag;
  logic       taken;
  logic       arm;

  assign op    = bus.instr_data[8:6];
  assign cond  = bus.instr_data[5:4];
  assign field = bus.instr_data[3:0];

  // Instruction decode, gated so nothing has an effect outside RUN.
  always_comb begin
    run     = (state_q == ST_RUN);
    is_cmp  = run && (op == OP_CMP);
    is_bra  = run && (op == OP_BRA);
    is_brr  = run && (op == OP_BRR);
    is_halt = run && (bus.instr_data == HALT_INSTR);
    case (cond)
      2'b01:   sel_flag = eq_q;
      2'b10:   sel_flag = lt_q;
      2'b11:   sel_flag = gt_q;
      default: sel_flag = 1'b0;
    endcase
    taken = (is_bra || is_brr) && (cond != 2'b00) && sel_flag;
    arm   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  // Combinational branch request outputs toward the PC.
  always_comb begin
    bus.cond_sel          = 2'b00;
    bus.abs_branch_en     = 1'b0;
    bus.rel_branch_en     = 1'b0;
    bus.rel_branch_offset = 4'sd0;
    bus.next_pc           = '0;
    if (is_bra) begin
      bus.cond_sel      = cond;
      bus.abs_branch_en = 1'b1;
      bus.next_pc       = lut_q[field];
    end else if (is_brr) begin
      bus.cond_sel          = cond;
      bus.rel_branch_en     = 1'b1;
      bus.rel_branch_offset = field;
    end
  end

  assign bus.instr_addr  = bus.current_pc;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.EQ          = eq_q;
  assign bus.LT          = lt_q;
  assign bus.GT          = gt_q;
  assign bus.taken_count = taken_count_q;

  // Sequencer next state: start is level-sensitive and must drop before RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start)  state_d = ST_ARMED;
      ST_ARMED: if (!bus.start) state_d = ST_RUN;
      ST_RUN:   if (is_halt)    state_d = ST_DONE;
      ST_DONE:  if (bus.start)  state_d = ST_ARMED;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Compare flags update on CMP only (unsigned), otherwise hold.
  always_comb begin
    eq_d = eq_q;
    lt_d = lt_q;
    gt_d = gt_q;
    if (is_cmp) begin
      eq_d = (bus.cmp_a == bus.cmp_b);
      lt_d = (bus.cmp_a <  bus.cmp_b);
      gt_d = (bus.cmp_a >  bus.cmp_b);
    end
  end

  // Taken counter: cleared when a new program is armed, saturating otherwise.
  always_comb begin
    taken_count_d = taken_count_q;
    if (arm)
      taken_count_d = '0;
    else if (taken && (taken_count_q != 16'hFFFF))
      taken_count_d = taken_count_q + 16'd1;
  end

  // Target table write; reads see the pre-write contents until the next edge.
  always_comb begin
    lut_d = lut_q;
    if (bus.lut_we)
      lut_d[bus.lut_waddr] = bus.lut_wdata;
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      eq_q          <= 1'b0;
      lt_q          <= 1'b0;
      gt_q          <= 1'b0;
      taken_count_q <= '0;
      for (int i = 0; i < 16; i++)
        lut_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      eq_q          <= eq_d;
      lt_q          <= lt_d;
      gt_q          <= gt_d;
      taken_count_q <= taken_count_d;
      lut_q         <= lut_d;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a vector table applied one per cycle in
// RUN, plus hand-written sequences for start/halt and asynchronous reset.
module tb_branch_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  branch_unit_if #(.PC_WIDTH(12), .DATA_WIDTH(8), .INSTR_WIDTH(9)) bif ();

  branch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  instr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        we;
    logic [3:0]  wa;
    logic [11:0] wd;
    logic [1:0]  cond;
    logic        abs_en;
    logic        rel_en;
    logic [3:0]  off;
    logic [11:0] npc;
    logic [2:0]  flags;   // {EQ, LT, GT} before this row's edge
    logic [15:0] tc;      // taken_count before this row's edge
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " cond_sel"}, 32'(bif.cond_sel), 32'd0);
    chk({tag, " abs_en"},   32'(bif.abs_branch_en), 32'd0);
    chk({tag, " rel_en"},   32'(bif.rel_branch_en), 32'd0);
    chk({tag, " next_pc"},  32'(bif.next_pc), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;

    //          instr    a      b      we    wa     wd       cond   abs   rel   off    npc       flags   tc
    vecs[0]  = '{9'h000, 8'd5,  8'd9,  1'b0, 4'd0,  12'h000, 2'd0,  1'b0, 1'b0, 4'h0, 12'h000, 3'b000, 16'd0};
    vecs[1]  = '{9'h180, 8'd5,  8'd9,  1'b0, 4'd0,  12'h000, 2'd0,  1'b0, 1'b0, 4'h0, 12'h000, 3'b000, 16'd0};
    vecs[2]  = '{9'h16E, 8'd5,  8'd9,  1'b0, 4'd0,  12'h000, 2'd2,  1'b0, 1'b1, 4'hE, 12'h000, 3'b010, 16'd0};
    vecs[3]  = '{9'h000, 8'd5,  8'd9,  1'b1, 4'd3,  12'h0A5, 2'd0,  1'b0, 1'b0, 4'h0, 12'h000, 3'b010, 16'd1};
    vecs[4]  = '{9'h1D3, 8'd5,  8'd9,  1'b0, 4'd0,  12'h000, 2'd1,  1'b1, 1'b0, 4'h0, 12'h0A5, 3'b010, 16'd1};
    vecs[5]  = '{9'h000, 8'd5,  8'd9,  1'b0, 4'd0,  12'h000, 2'd0,  1'b0, 1'b0, 4'h0, 12'h000, 3'b010, 16'd1};
    vecs[6]  = '{9'h1D7, 8'd5,  8'd9,  1'b1, 4'd7,  12'h111, 2'd1,  1'b1, 1'b0, 4'h0, 12'h000, 3'b010, 16'd1};
    vecs[7]  = '{9'h1D7, 8'd5,  8'd9,  1'b0, 4'd0,  12'h000, 2'd1,  1'b1, 1'b0, 4'h0, 12'h111, 3'b010, 16'd1};
    vecs[8]  = '{9'h180, 8'd9,  8'd9,  1'b0, 4'd0,  12'h000, 2'd0,  1'b0, 1'b0, 4'h0, 12'h000, 3'b010, 16'd1};
    vecs[9]  = '{9'h1D7, 8'd9,  8'd9,  1'b0, 4'd0,  12'h000, 2'd1,  1'b1, 1'b0, 4'h0, 12'h111, 3'b100, 16'd1};
    vecs[10] = '{9'h180, 8'd200,8'd3,  1'b0, 4'd0,  12'h000, 2'd0,  1'b0, 1'b0, 4'h0, 12'h000, 3'b100, 16'd2};
    vecs[11] = '{9'h171, 8'd200,8'd3,  1'b0, 4'd0,  12'h000, 2'd3,  1'b0, 1'b1, 4'h1, 12'h000, 3'b001, 16'd2};
    vecs[12] = '{9'h145, 8'd200,8'd3,  1'b0, 4'd0,  12'h000, 2'd0,  1'b0, 1'b1, 4'h5, 12'h000, 3'b001, 16'd3};
    vecs[13] = '{9'h100, 8'd200,8'd3,  1'b0, 4'd0,  12'h000, 2'd0,  1'b0, 1'b0, 4'h0, 12'h000, 3'b001, 16'd3};
    vecs[14] = '{9'h03E, 8'd200,8'd3,  1'b0, 4'd0,  12'h000, 2'd0,  1'b0, 1'b0, 4'h0, 12'h000, 3'b001, 16'd3};

    reset          = 1'b1;
    bif.start      = 1'b0;
    bif.current_pc = 12'h123;
    bif.instr_data = 9'h1D3;
    bif.cmp_a      = 8'd0;
    bif.cmp_b      = 8'd0;
    bif.lut_we     = 1'b0;
    bif.lut_waddr  = 4'd0;
    bif.lut_wdata  = 12'h000;

    // Reset state
    @(negedge clk);
    #2;
    chk("rst done", 32'(bif.done), 32'd0);
    chk("rst flags", 32'({bif.EQ, bif.LT, bif.GT}), 32'd0);
    chk("rst taken_count", 32'(bif.taken_count), 32'd0);
    chk("rst instr_addr", 32'(bif.instr_addr), 32'h123);
    chk_idle_outs("rst");
    reset = 1'b0;

    // Start held for three cycles: outputs stay quiet through IDLE/ARMED
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bif.start = 1'b1;
      #2;
      chk($sformatf("start%0d abs_en", c), 32'(bif.abs_branch_en), 32'd0);
      chk($sformatf("start%0d done", c), 32'(bif.done), 32'd0);
    end
    @(negedge clk);
    bif.start = 1'b0;
    #2;
    chk("armed abs_en", 32'(bif.abs_branch_en), 32'd0);

    // Table-driven run
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bif.instr_data = vecs[i].instr;
      bif.cmp_a      = vecs[i].a;
      bif.cmp_b      = vecs[i].b;
      bif.lut_we     = vecs[i].we;
      bif.lut_waddr  = vecs[i].wa;
      bif.lut_wdata  = vecs[i].wd;
      bif.current_pc = 12'(i * 3);
      #2;
      chk($sformatf("v%0d cond_sel", i), 32'(bif.cond_sel), 32'(vecs[i].cond));
      chk($sformatf("v%0d abs_en", i), 32'(bif.abs_branch_en), 32'(vecs[i].abs_en));
      chk($sformatf("v%0d rel_en", i), 32'(bif.rel_branch_en), 32'(vecs[i].rel_en));
      chk($sformatf("v%0d offset", i), 32'($unsigned(bif.rel_branch_offset)), 32'(vecs[i].off));
      chk($sformatf("v%0d next_pc", i), 32'(bif.next_pc), 32'(vecs[i].npc));
      chk($sformatf("v%0d flags", i), 32'({bif.EQ, bif.LT, bif.GT}), 32'(vecs[i].flags));
      chk($sformatf("v%0d taken_count", i), 32'(bif.taken_count), 32'(vecs[i].tc));
      chk($sformatf("v%0d instr_addr", i), 32'(bif.instr_addr), 32'(i * 3));
      chk($sformatf("v%0d done", i), 32'(bif.done), 32'd0);
    end

    // HALT retires into DONE
    @(negedge clk);
    bif.lut_we     = 1'b0;
    bif.instr_data = 9'h03F;
    #2;
    chk("halt done pre", 32'(bif.done), 32'd0);
    chk_idle_outs("halt");
    @(negedge clk);
    bif.instr_data = 9'h1D3;
    #2;
    chk("done set", 32'(bif.done), 32'd1);
    chk_idle_outs("done");
    @(negedge clk);
    bif.instr_data = 9'h03F;
    #2;
    chk("done hold", 32'(bif.done), 32'd1);

    // Re-arm: counter clears, done drops
    @(negedge clk);
    bif.start      = 1'b1;
    bif.instr_data = 9'h000;
    #2;
    chk("rearm tc pre", 32'(bif.taken_count), 32'd3);
    @(negedge clk);
    #2;
    chk("rearm done", 32'(bif.done), 32'd0);
    chk("rearm taken_count", 32'(bif.taken_count), 32'd0);
    bif.start = 1'b0;
    @(negedge clk);
    bif.instr_data = 9'h171;
    #2;
    chk("run2 rel_en", 32'(bif.rel_branch_en), 32'd1);
    chk("run2 flags kept", 32'({bif.EQ, bif.LT, bif.GT}), 32'b001);
    @(negedge clk);
    bif.instr_data = 9'h1D3;
    #2;
    chk("run2 taken_count", 32'(bif.taken_count), 32'd1);
    chk("run2 next_pc", 32'(bif.next_pc), 32'h0A5);

    // Asynchronous reset mid-RUN, between clock edges
    #1;
    reset = 1'b1;
    #1;
    chk("arst done", 32'(bif.done), 32'd0);
    chk("arst flags", 32'({bif.EQ, bif.LT, bif.GT}), 32'd0);
    chk("arst taken_count", 32'(bif.taken_count), 32'd0);
    chk("arst instr_addr", 32'(bif.instr_addr), 32'(12'(14 * 3)));
    chk_idle_outs("arst");
    @(negedge clk);
    reset     = 1'b0;
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    @(negedge clk);
    #2;
    chk("post-rst abs_en", 32'(bif.abs_branch_en), 32'd1);
    chk("post-rst LUT3", 32'(bif.next_pc), 32'd0);
    bif.instr_data = 9'h1D7;
    #1;
    chk("post-rst LUT7", 32'(bif.next_pc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Control-side counterpart of the program counter: decodes the instruction at current_pc and drives cond_sel, abs_branch_en, rel_branch_en, rel_branch_offset and next_pc back into the PC.
- Owns the EQ/LT/GT compare flag registers, a 16-entry absolute branch-target lookup table (LUT) and the start/done program sequencer handshake with the test bench.
- Sits between instruction memory and the PC; instruction fetch is combinational, while flags, LUT, FSM and statistics are registered.

Parameters:
- PC_WIDTH, 12, width of PC, LUT entries and next_pc.
- DATA_WIDTH, 8, width of compare operands.
- INSTR_WIDTH, 9, instruction width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  bench request to begin the next program; level-sensitive.
- done  out  1  program finished (HALT retired).
- current_pc  in  PC_WIDTH  from PC.
- instr_addr  out  PC_WIDTH  equals current_pc (combinational).
- instr_data  in  INSTR_WIDTH  instruction memory read data, same cycle.
- cmp_a  in  DATA_WIDTH  compare operand A from register file.
- cmp_b  in  DATA_WIDTH  compare operand B from register file.
- EQ  out  1  registered flag.
- LT  out  1  registered flag.
- GT  out  1  registered flag.
- cond_sel  out  2  00 none, 01 EQ, 10 LT, 11 GT.
- abs_branch_en  out  1  absolute branch request.
- rel_branch_en  out  1  relative branch request.
- rel_branch_offset  out  4  signed relative offset.
- next_pc  out  PC_WIDTH  absolute target read from the LUT.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  4  LUT write index.
- lut_wdata  in  PC_WIDTH  LUT write data.
- taken_count  out  16  count of taken branches in the current program.

Behaviour:
- Decode uses op = instr_data[8:6]:
  - 110 CMP.
  - 111 BRA: cond = [5:4], LUT index = [3:0].
  - 101 BRR: cond = [5:4], offset = [3:0].
  - 9'b000111111 HALT.
  - Anything else: no control effect.
- FSM states IDLE, ARMED, RUN, DONE:
  - IDLE --start=1--> ARMED.
  - ARMED --start=0--> RUN.
  - RUN --HALT decoded--> DONE.
  - DONE --start=1--> ARMED.
  - start=1 in RUN or ARMED is ignored.
- Outputs are active only in RUN. In any other state, cond_sel=00, abs_branch_en=0, rel_branch_en=0, rel_branch_offset=0 and next_pc=0, all combinational.
- BRA in RUN: cond_sel=cond, abs_branch_en=1, next_pc=LUT[index], all in the same cycle.
- BRR in RUN: cond_sel=cond, rel_branch_en=1, rel_branch_offset=offset.
- abs_branch_en and rel_branch_en are never both 1.
- CMP in RUN: at the next posedge, EQ=(a==b), LT=(a<b), GT=(a>b), unsigned compare; exactly one flag ends up set. Flags hold otherwise. A branch in the cycle after a CMP sees the new flags.
- Taken branch = BRA/BRR in RUN with cond≠00 and the selected flag =1.
  - taken_count increments by 1 at the posedge of each taken branch and saturates at 16'hFFFF.
  - taken_count clears to 0 on the IDLE→ARMED and DONE→ARMED transitions.
- HALT in RUN: the FSM enters DONE at the next posedge. done=1 in DONE only (registered state decode). HALT outside RUN has no effect.
- LUT:
  - Write at posedge when lut_we=1, in any state.
  - Read is combinational. A write and a read of the same index in the same cycle returns the old value; the new value is visible next cycle.
- Reset (asynchronous, any time including mid-RUN): FSM=IDLE, EQ=LT=GT=0, all LUT entries=0, taken_count=0, done=0. All branch outputs are 0 immediately.
- instr_addr=current_pc always, including during reset.

Test Plan:
- Reset, then start=1 for 3 cycles, then start=0 -> FSM reaches RUN one cycle after start falls; branch outputs stay 0 while start=1; done=0.
- In RUN, cmp_a=5, cmp_b=9, CMP, then BRR cond=10 offset=4'hE -> LT=1, EQ=GT=0; next cycle cond_sel=10, rel_branch_en=1, rel_branch_offset=4'hE; taken_count 0→1.
- Write LUT[3]=12'h0A5, then BRA cond=01 index 3 with EQ=0 -> next_pc=12'h0A5, abs_branch_en=1, cond_sel=01; taken_count unchanged.
- lut_we=1 to LUT[7]=12'h111 in the same cycle as BRA index 7 (old value 0) -> next_pc=0 that cycle; a repeat BRA the next cycle gives 12'h111.
- HALT in RUN -> done=1 the next cycle; branch outputs 0; start=1 -> ARMED, done=0, taken_count=0.
- Assert reset mid-RUN after a taken branch -> done=0, flags=0, taken_count=0, LUT[3] reads 0, outputs 0 asynchronously before the next clk edge.
